pwm_tick_unit: RTL and testbench

Timing core pairing a programmable step-tick downcounter with a fixed-period PWM generator, both on one clock.
- The tick (`zero`) paces an external up-counter, such as a sawtooth ramp, which feeds back into `duty_cycle`.
- `pwm_out` drives the RC-filtered DAC path.
- Both halves share `clk`, `reset` and `enable`, but are otherwise independent.

---
 rtl/pwm_tick_unit.sv | 101 ++++++++++
 tb/tb_pwm_tick_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_tick_unit.sv
// Step-tick downcounter plus fixed-period PWM generator sharing one clock.
// The tick paces an external ramp; the PWM output feeds an RC-filtered DAC.
module pwm_tick_unit #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 390
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_cycle,
  output logic             zero,
  output logic             pwm_out
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PERIOD - 1);

  generate
    if (PERIOD < 1) begin : g_bad_period
      $error("pwm_tick_unit: PERIOD must be >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Tick downcounter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_at_zero;

  assign cnt_at_zero = (cnt_q == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = cnt_at_zero ? CNT_RELOAD : cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reset is folded in so the tick stays low during the reset cycle even when
  // the count already sits at zero (always the case for PERIOD == 1).
  assign zero = enable && !reset && cnt_at_zero;

  // ---------------------------------------------------------------------------
  // PWM generator
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pcnt_q;
  logic [WIDTH-1:0] pcnt_d;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;
  logic [WIDTH-1:0] duty_eff;
  logic             pwm_q;
  logic             pwm_d;
  logic             period_start;

  assign period_start = (pcnt_q == '0);

  // Duty is captured only at period start so a mid-period change cannot
  // produce a runt or stretched pulse; it applies from the next period.
  assign duty_eff = period_start ? duty_cycle : duty_q;

  always_comb begin
    pcnt_d = '0;
    duty_d = duty_q;
    pwm_d  = 1'b0;
    if (enable) begin
      pcnt_d = pcnt_q + 1'b1;
      pwm_d  = (pcnt_q < duty_eff);
      if (period_start) begin
        duty_d = duty_cycle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_tick_unit.sv
// Randomized self-checking bench for pwm_tick_unit at PERIOD 390, 4 and 1,
// compared cycle by cycle against an arithmetic model of the tick and PWM rules.
module tb_pwm_tick_unit;

  localparam int W    = 8;
  localparam int PMAX = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] duty;

  logic zero_a, pwm_a;  // PERIOD = 390
  logic zero_b, pwm_b;  // PERIOD = 4
  logic zero_c, pwm_c;  // PERIOD = 1

  always #5 clk = ~clk;

  pwm_tick_unit #(.WIDTH(W), .PERIOD(390)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .duty_cycle(duty),
    .zero(zero_a), .pwm_out(pwm_a)
  );
  pwm_tick_unit #(.WIDTH(W), .PERIOD(4)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .duty_cycle(duty),
    .zero(zero_b), .pwm_out(pwm_b)
  );
  pwm_tick_unit #(.WIDTH(W), .PERIOD(1)) u_dut_c (
    .clk(clk), .reset(reset), .enable(enable), .duty_cycle(duty),
    .zero(zero_c), .pwm_out(pwm_c)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: enabled edges since reset, position within the current
  // enabled run, and the duty latched at the start of the current PWM period.
  int   n_en      = 0;
  int   run_len   = 0;
  int   lat_duty  = 0;
  logic exp_pwm   = 1'b0;
  bit   pwm_known = 1'b0;

  int step_idx   = 0;
  int first_tick = -1;
  int tick_cnt_a = 0;
  int tick_cnt_b = 0;
  int hi_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_zero(input int period);
    return enable && !reset && ((n_en % period) == (period - 1));
  endfunction

  // One clock: drive inputs after the falling edge, check the combinational
  // tick and the registered PWM, then advance the model on the rising edge.
  task automatic step(input logic r, input logic e, input logic [W-1:0] d);
    int ph;
    @(negedge clk);
    reset  = r;
    enable = e;
    duty   = d;
    step_idx++;
    #1;
    check("zero_p390", zero_a, exp_zero(390));
    check("zero_p4",   zero_b, exp_zero(4));
    check("zero_p1",   zero_c, exp_zero(1));
    if (pwm_known) begin
      check("pwm_p390", pwm_a, exp_pwm);
      check("pwm_p4",   pwm_b, exp_pwm);
      check("pwm_p1",   pwm_c, exp_pwm);
    end
    if (zero_a === 1'b1) begin
      tick_cnt_a++;
      if (first_tick < 0) first_tick = step_idx;
    end
    if (zero_b === 1'b1) tick_cnt_b++;

    @(posedge clk);
    if (r) begin
      n_en      = 0;
      run_len   = 0;
      lat_duty  = 0;
      exp_pwm   = 1'b0;
      pwm_known = 1'b1;
      step_idx  = 0;
    end else if (!e) begin
      run_len = 0;
      exp_pwm = 1'b0;
    end else begin
      ph = run_len % PMAX;
      if (ph == 0) lat_duty = int'(d);
      exp_pwm = (ph < lat_duty);
      run_len++;
      n_en++;
    end
    #1;
    if (pwm_a === 1'b1) hi_cnt++;
  endtask

  initial begin
    int   k;
    logic r_rand;
    logic e_rand;
    logic [W-1:0] cur_duty;

    reset  = 1'b1;
    enable = 1'b0;
    duty   = '0;

    // Tick spacing at PERIOD = 390 from power-up.
    step(1'b1, 1'b0, 8'd0);
    tick_cnt_a = 0;
    first_tick = -1;
    repeat (3900) step(1'b0, 1'b1, 8'd0);
    check("ticks_in_3900", tick_cnt_a, 10);
    check("first_tick_cycle", first_tick, 390);

    // Enable low mid-count freezes the PERIOD = 4 counter without slip.
    step(1'b1, 1'b0, 8'd0);
    repeat (6) step(1'b0, 1'b1, 8'd0);
    tick_cnt_b = 0;
    repeat (50) step(1'b0, 1'b0, 8'd0);
    check("p4_ticks_while_idle", tick_cnt_b, 0);
    tick_cnt_b = 0;
    k = 0;
    while (tick_cnt_b == 0 && k < 10) begin
      step(1'b0, 1'b1, 8'd0);
      k++;
    end
    check("p4_resume_gap", k, 2);

    // Steady duty values over whole periods.
    step(1'b1, 1'b0, 8'd0);
    hi_cnt = 0;
    step(1'b0, 1'b1, 8'd64);
    check("rise_after_c0", pwm_a, 1);
    repeat (511) step(1'b0, 1'b1, 8'd64);
    check("duty64_hi_2per", hi_cnt, 128);
    hi_cnt = 0;
    repeat (256) step(1'b0, 1'b1, 8'd0);
    check("duty0_hi", hi_cnt, 0);
    hi_cnt = 0;
    repeat (256) step(1'b0, 1'b1, 8'd255);
    check("duty255_hi", hi_cnt, 255);

    // Duty change mid-period applies from the next period only.
    step(1'b1, 1'b0, 8'd0);
    hi_cnt = 0;
    repeat (100) step(1'b0, 1'b1, 8'd64);
    repeat (156) step(1'b0, 1'b1, 8'd192);
    check("dchg_current_period", hi_cnt, 64);
    hi_cnt = 0;
    repeat (256) step(1'b0, 1'b1, 8'd192);
    check("dchg_next_period", hi_cnt, 192);

    // One-cycle reset mid-operation restarts everything as from power-up.
    repeat (37) step(1'b0, 1'b1, 8'd200);
    step(1'b1, 1'b1, 8'd200);
    check("pwm_after_reset", pwm_a, 0);
    tick_cnt_a = 0;
    first_tick = -1;
    repeat (400) step(1'b0, 1'b1, 8'd200);
    check("first_tick_after_reset", first_tick, 390);
    check("ticks_after_reset", tick_cnt_a, 1);

    // Randomized traffic: sporadic resets, enable drop-outs and duty changes.
    cur_duty = 8'(($urandom) & 8'hFF);
    repeat (4000) begin
      r_rand = (($urandom % 300) == 0);
      e_rand = (($urandom % 8) != 0);
      if (($urandom % 64) == 0) cur_duty = 8'(($urandom) & 8'hFF);
      step(r_rand, e_rand, cur_duty);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
